// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store initiator: funct3 size field, FSM state codes,
// byte-lane mask constants and the access-size alignment helper.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_ADDR = 3'd1;
  localparam logic [2:0] S_LD_DATA = 3'd2;
  localparam logic [2:0] S_ST      = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [31:0] MASK_B = 32'h0000_00FF;
  localparam logic [31:0] MASK_H = 32'h0000_FFFF;
  localparam logic [31:0] MASK_W = 32'hFFFF_FFFF;

  // Byte offset of the access once rounded down to its natural size boundary.
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    if (size == SIZE_B) return off;
    if (size == SIZE_H) return {off[1], 1'b0};
    return 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response channel between the CPU memory stage (master) and the
// load/store initiator (slave).
interface mem_access_unit_if #(parameter int WORD_LEN = 32);
  // A request transfers on a rising edge where req_valid && req_ready; req_* are only
  // sampled on that edge. resp_valid is a one-cycle pulse with no back-pressure.
  logic                req_valid;
  logic                req_ready;
  logic                req_wen;
  logic [2:0]          req_funct3;
  logic [WORD_LEN-1:0] req_addr;
  logic [WORD_LEN-1:0] req_wdata;
  logic                resp_valid;
  logic [WORD_LEN-1:0] resp_rdata;
  logic                resp_fault;

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane handling: store data replication and mask generation,
// load lane selection with sign/zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [31:0] st_wmask,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  always_comb begin
    st_wdata = st_data;
    st_wmask = MASK_W;
    case (st_funct3[1:0])
      SIZE_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wmask = MASK_B << {st_off, 3'b000};
      end
      SIZE_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wmask = MASK_H << {st_off[1], 4'b0000};
      end
      default: ;
    endcase
  end

  // Offsets arrive already aligned to the access size, so one shift serves both widths.
  always_comb begin
    ld_shift = ld_word >> {ld_off, 3'b000};
    ld_data  = ld_word;
    case (ld_funct3[1:0])
      SIZE_B: ld_data = ld_funct3[2] ? {24'h0, ld_shift[7:0]}
                                     : {{24{ld_shift[7]}}, ld_shift[7:0]};
      SIZE_H: ld_data = ld_funct3[2] ? {16'h0, ld_shift[15:0]}
                                     : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the data port of the unified memory.
// Optional macro MEM_ACCESS_MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of aligning down.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WORD_LEN = 32,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_unit_if.slave    req_if,
  output logic [WORD_LEN-1:0] d_addr,
  output logic                wen,
  output logic [WORD_LEN-1:0] wmask,
  output logic [WORD_LEN-1:0] wdata,
  input  logic [WORD_LEN-1:0] rdata,
  input  logic                data_ready,
  output logic [2:0]          dbg_state
);

  localparam int CNT_W = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);

  logic [2:0]          state;
  logic [2:0]          funct3_q;
  logic [1:0]          off_q;
  logic [CNT_W-1:0]    cnt;
  logic                resp_valid_q;
  logic                resp_fault_q;
  logic [WORD_LEN-1:0] resp_rdata_q;

  logic [1:0]          req_size;
  logic [1:0]          req_off;
  logic                trap;
  logic [WORD_LEN-1:0] st_wdata;
  logic [WORD_LEN-1:0] st_wmask;
  logic [WORD_LEN-1:0] ld_data;

  assign req_size = req_if.req_funct3[1:0];
  assign req_off  = align_off(req_size, req_if.req_addr[1:0]);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign trap = ((req_size == SIZE_H) && req_if.req_addr[0]) ||
                (req_size[1] && (req_if.req_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  mem_lane_align u_lane (
    .st_funct3 (req_if.req_funct3),
    .st_off    (req_off),
    .st_data   (req_if.req_wdata),
    .st_wdata  (st_wdata),
    .st_wmask  (st_wmask),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .ld_word   (rdata),
    .ld_data   (ld_data)
  );

  assign req_if.req_ready  = (state == S_IDLE);
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_rdata = resp_rdata_q;
  assign req_if.resp_fault = resp_fault_q;
  assign dbg_state         = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      cnt          <= '0;
      d_addr       <= '0;
      wen          <= 1'b0;
      wmask        <= '0;
      wdata        <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_if.req_valid) begin
            funct3_q <= req_if.req_funct3;
            off_q    <= req_off;
            cnt      <= '0;
            if (trap) begin
              state        <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= '0;
            end else if (req_if.req_wen) begin
              state  <= S_ST;
              wen    <= 1'b1;
              d_addr <= {req_if.req_addr[WORD_LEN-1:2], 2'b00};
              wmask  <= st_wmask;
              wdata  <= st_wdata;
            end else begin
              state  <= S_LD_ADDR;
              d_addr <= {req_if.req_addr[WORD_LEN-1:2], 2'b00};
            end
          end
        end
        S_LD_ADDR: state <= S_LD_DATA;
        S_LD_DATA: begin
          state        <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= ld_data;
        end
        // Stay in ST until the memory acknowledges; the cycle count caps a stuck write.
        S_ST: begin
          if (data_ready) begin
            state        <= S_RESP;
            wen          <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state        <= S_RESP;
            wen          <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a two-phase read-modify-write memory model
// and a scoreboard of expected responses.
module tb_mem_access_unit;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_addr, wmask, wdata, rdata;
  logic        wen, data_ready;
  logic [2:0]  dbg_state;

  mem_access_unit_if #(.WORD_LEN(32)) bus ();

  mem_access_unit #(.WORD_LEN(32), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_if     (bus),
    .d_addr     (d_addr),
    .wen        (wen),
    .wmask      (wmask),
    .wdata      (wdata),
    .rdata      (rdata),
    .data_ready (data_ready),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];
  logic        mem_loaded = 1'b0;
  logic        rmw_phase;
  logic        no_ready;
  logic        full_mask;

  assign full_mask  = (wmask == 32'hFFFF_FFFF);
  assign data_ready = wen && !no_ready && (full_mask || rmw_phase);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_phase <= 1'b0;
      if (!mem_loaded) begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        mem[32'h100 >> 2] <= 32'h8433_2211;
        mem_loaded <= 1'b1;
      end
    end else if (!wen) begin
      rmw_phase <= 1'b0;
    end else if (data_ready) begin
      mem[d_addr[11:2]] <= (mem[d_addr[11:2]] & ~wmask) | (wdata & wmask);
      rmw_phase <= 1'b0;
    end else if (!full_mask) begin
      rmw_phase <= 1'b1;
    end
  end

  always @(posedge clk) rdata <= mem[d_addr[11:2]];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", {63'b0, bus.resp_valid}, 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("resp_rdata", bus.resp_rdata, e[31:0]);
        check("resp_fault", bus.resp_fault, e[32]);
      end
    end
  end

  function automatic logic [31:0] exp_mask(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 32'h0000_00FF << (8 * a[1:0]);
      2'b01:   return 32'h0000_FFFF << (16 * a[1]);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ld_expect(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [32:0] exp,
                        input int exp_lat, input int exp_wen);
    int lat;
    int wen_n;
    bit done;
    @(negedge clk);
    check("req_ready", bus.req_ready, 1);
    exp_q.push_back(exp);
    bus.req_valid  = 1'b1;
    bus.req_wen    = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = 0;
    wen_n = 0;
    done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && exp_lat > 1) check("d_addr", d_addr, {a[31:2], 2'b00});
      if (wen) begin
        if (wen_n == 0) begin
          check("wmask", wmask, exp_mask(f3, a));
          check("wdata", wdata, exp_wdata(f3, d));
        end
        wen_n++;
      end
      if (bus.resp_valid) done = 1;
    end
    check("resp_latency", lat, exp_lat);
    check("wen_cycles", wen_n, exp_wen);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] ref_w [0:15];
  logic [1:0]  sz, off;
  logic [3:0]  wi;
  logic [31:0] ra, rd, rm;
  logic        rw, ru;
  logic [2:0]  rf3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    no_ready = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wen = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < 16; i++) ref_w[i] = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_wen", wen, 0);
    check("rst_d_addr", d_addr, 0);
    check("rst_wmask", wmask, 0);
    check("rst_wdata", wdata, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_fault", bus.resp_fault, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    // Loads from the word at 0x100 = 0x84332211.
    do_req(0, F_B,  32'h103, 32'h0, {1'b0, 32'hFFFF_FF84}, 3, 0);
    do_req(0, F_BU, 32'h103, 32'h0, {1'b0, 32'h0000_0084}, 3, 0);
    do_req(0, F_H,  32'h102, 32'h0, {1'b0, 32'hFFFF_8433}, 3, 0);
    do_req(0, F_W,  32'h100, 32'h0, {1'b0, 32'h8433_2211}, 3, 0);

    // Full-mask store, then partial-mask store into the same word.
    do_req(1, F_W, 32'h200, 32'hDEAD_BEEF, {1'b0, 32'h0}, 2, 1);
    do_req(1, F_B, 32'h201, 32'h0000_00AA, {1'b0, 32'h0}, 3, 2);
    do_req(0, F_W, 32'h200, 32'h0, {1'b0, 32'hDEAD_AAEF}, 3, 0);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    do_req(0, F_W, 32'h102, 32'h0, {1'b1, 32'h0}, 1, 0);
    do_req(1, F_H, 32'h401, 32'h0000_1234, {1'b1, 32'h0}, 1, 0);
    do_req(0, F_W, 32'h400, 32'h0, {1'b0, 32'h0}, 3, 0);
`else
    do_req(0, F_W, 32'h102, 32'h0, {1'b0, 32'h8433_2211}, 3, 0);
    do_req(1, F_H, 32'h401, 32'h0000_1234, {1'b0, 32'h0}, 3, 2);
    do_req(0, F_W, 32'h400, 32'h0, {1'b0, 32'h0000_1234}, 3, 0);
`endif

    // Memory never acknowledges: the store must give up after 15 write cycles.
    no_ready = 1'b1;
    do_req(1, F_W, 32'h300, 32'h1234_5678, {1'b1, 32'h0}, 16, 15);
    no_ready = 1'b0;
    check("timeout_wen_low", wen, 0);
    do_req(0, F_W, 32'h300, 32'h0, {1'b0, 32'h0}, 3, 0);

    // Reset during the read phase of a partial store aborts it.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wen = 1'b1;
    bus.req_funct3 = F_H;
    bus.req_addr = 32'h202;
    bus.req_wdata = 32'h0000_5555;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_wen_before", wen, 1);
    rst = 1'b1;
    #1;
    check("abort_wen_drop", wen, 0);
    check("abort_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_req_ready", bus.req_ready, 1);
    do_req(0, F_W, 32'h200, 32'h0, {1'b0, 32'hDEAD_AAEF}, 3, 0);

    // Random aligned traffic in a 16-word window tracked by ref_w.
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 2));
      wi = 4'($urandom_range(0, 15));
      rw = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      rd = $urandom;
      if (sz == 2'b00)      off = 2'($urandom_range(0, 3));
      else if (sz == 2'b01) off = {1'($urandom_range(0, 1)), 1'b0};
      else                  off = 2'b00;
      ra = 32'h500 | {26'h0, wi, off};
      if (rw) begin
        rf3 = {1'b0, sz};
        rm = exp_mask(rf3, ra);
        ref_w[wi] = (ref_w[wi] & ~rm) | (exp_wdata(rf3, rd) & rm);
        do_req(1, rf3, ra, rd, {1'b0, 32'h0}, (sz == 2'b10) ? 2 : 3, (sz == 2'b10) ? 1 : 2);
      end else begin
        rf3 = {(sz == 2'b10) ? 1'b0 : ru, sz};
        do_req(0, rf3, ra, 32'h0, {1'b0, ld_expect(ref_w[wi], rf3, off)}, 3, 0);
      end
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
